// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
// State encoding and rate defaults for the baud tick logic.
package uart_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        PENDING  = 2'd2
    } brc_state_t;

    localparam int UART_OS_RATE     = 16;
    localparam int UART_DEFAULT_DIV = 100;

endpackage

// File: rtl/baud_tick_counter.sv
// Loadable divide-by-N counter.
// Emits a one-cycle tick every div cycles while run is high.
module baud_tick_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_m1;

    assign div_m1 = div - WIDTH'(1);
    assign tick   = run && (cnt == div_m1);

    // Count up to div-1 and wrap; clear has priority over wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/baud_rate_controller.sv
// Runtime-programmable baud tick source.
// Defers divisor changes until the serial link is idle.
module baud_rate_controller
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int OS_RATE     = UART_OS_RATE,
    parameter int OS_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 link_busy,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 os_tick,
    output logic                 bit_tick,
    output logic                 running
);

    brc_state_t           state;
    logic [DIV_WIDTH-1:0] pend_div;
    logic [OS_WIDTH-1:0]  phase;
    logic                 acc;
    logic                 div_good;
    logic                 acc_ok;
    logic                 acc_bad;
    logic                 cnt_run;
    logic                 cnt_clr;
    logic                 phase_last;

    assign acc        = cfg_valid && cfg_ready;
    assign div_good   = cfg_div >= DIV_WIDTH'(2);
    assign acc_ok     = acc && div_good;
    assign acc_bad    = acc && !div_good;
    assign cnt_run    = state != DISABLED;
    assign phase_last = phase == OS_WIDTH'(OS_RATE - 1);
    assign bit_tick   = os_tick && phase_last;

    // Counters restart whenever a divisor is applied or ticking stops.
    always_comb begin
        cnt_clr = 1'b1;
        unique case (state)
            DISABLED: cnt_clr = 1'b1;
            RUN:      cnt_clr = !en || (acc_ok && !link_busy);
            PENDING:  cnt_clr = !en || !link_busy;
            default:  cnt_clr = 1'b1;
        endcase
    end

    baud_tick_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .run   (cnt_run),
        .clr   (cnt_clr),
        .div   (div_active),
        .tick  (os_tick)
    );

    // Oversample phase: counts os_ticks, wraps after OS_RATE-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (cnt_clr) begin
            phase <= '0;
        end else if (os_tick) begin
            phase <= phase_last ? '0 : phase + OS_WIDTH'(1);
        end
    end

    // Control FSM: handshake, divisor apply/defer, registered status.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= DISABLED;
            div_active <= DIV_WIDTH'(DEFAULT_DIV);
            pend_div   <= '0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            running    <= 1'b0;
        end else begin
            cfg_err <= acc_bad;
            unique case (state)
                DISABLED: begin
                    if (acc_ok) div_active <= cfg_div;
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if (acc_ok) div_active <= cfg_div;
                        state   <= DISABLED;
                        running <= 1'b0;
                    end else if (acc_ok && !link_busy) begin
                        div_active <= cfg_div;
                    end else if (acc_ok) begin
                        pend_div  <= cfg_div;
                        state     <= PENDING;
                        cfg_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (!en || !link_busy) begin
                        div_active <= pend_div;
                        cfg_ready  <= 1'b1;
                        if (!en) begin
                            state   <= DISABLED;
                            running <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state     <= DISABLED;
                    cfg_ready <= 1'b1;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule
